weight_buffer: RTL
==================

# weight_buffer

Parametrised multi-lane weight store feeding the systolic array's weight-load path. It holds a DEPTH-word weight memory with a single-word write port. On a `start` command it streams `num_rows` consecutive lane-groups of LANES weights each, using a valid/ready handshake with backpressure. It is the successor to the fixed four-weight, 32-entry lookup: it adds parametrised width, depth and lanes, a row-streaming state machine, wrap-around addressing and a defined write/read collision rule.

## Interface
- DATA_W, 16, width of one weight
- DEPTH, 32, number of weight words (power of two)
- LANES, 4, weights delivered per row
- CNT_W, 8, width of the row count
- ADDR_W, $clog2(DEPTH), address width (derived)

One clock; reset is synchronous and active-high.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write word address
- wr_data  input  DATA_W  write data
- start  input  1  begin fetch; sampled only in IDLE
- base_addr  input  ADDR_W  address of lane 0 of row 0
- num_rows  input  CNT_W  rows to stream
- out_valid  output  1  out_weights holds a valid row
- out_ready  input  1  consumer accepts row
- out_weights  output  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W]
- out_last  output  1  current row is the final row
- busy  output  1  fetch in progress
- done  output  1  one-cycle pulse at fetch completion

## Operation
- Row k address: a_k = (base_addr + k*LANES) mod DEPTH. Lane i = mem[(a_k + i) mod DEPTH]. All address arithmetic wraps modulo DEPTH.
- FSM states: IDLE, FETCH.
- IDLE, start=1, num_rows>0: latch base and count, read row 0 into the output register, go to FETCH.
- IDLE, start=1, num_rows=0: stay in IDLE, pulse done next cycle, never assert out_valid.
- FETCH: on out_valid&&out_ready for a non-last row, load the next row the same edge. On the handshake of the last row, clear out_valid and return to IDLE.
- start in FETCH is ignored. A stalled row (out_valid&&!out_ready) holds out_weights and out_last stable.
- Writes are accepted in any state, every cycle. A read never stalls a write.
- Write/read collision: a lane whose address equals wr_addr while that lane is loaded into the output register in the same cycle is resolved per Configuration.
- Reset: out_valid, out_last, busy, done and out_weights go to 0, and the FSM goes to IDLE. Memory contents are not cleared. Reset mid-fetch aborts the fetch with no done pulse.

## Timing
- start accepted at edge t: out_valid=1 with row 0 from cycle t+1. busy=1 from t+1.
- Throughput is one row per cycle when out_ready is held high, so N rows occupy cycles t+1..t+N.
- out_last is asserted together with row num_rows-1.
- Last handshake at edge u: busy=0 and done=1 in cycle u+1 only. A new start is accepted at edge u+1.
- A write at edge w is visible to any row loaded at edge w+1 or later.

## Configuration
- WEIGHT_BUFFER_BYPASS_EN defined: a colliding lane returns wr_data (write-through forwarding).
- Undefined: a colliding lane returns the old memory word (read-before-write), and the new value is stored.

## Structure
- weight_buffer_pkg: the state enum (IDLE, FETCH), default parameter constants, and a lane-address wrap function.
- One sub-module, weight_buffer_ram. It holds the DEPTH×DATA_W storage with one write port and LANES wrapped read ports, and contains the collision/bypass logic. The FSM and handshake logic stay in weight_buffer.

## Test plan
- Write mem[i]=i+1 for i=0..31, then start with base=15, num_rows=1, out_ready=1 → at t+1 lanes = {16,17,18,19}, out_last=1, done pulses at t+2.
- base=30, num_rows=2 → row0 = {31,32,1,2} (wrap), row1 = {3,4,5,6}, out_last on row1 only.
- num_rows=3, out_ready low for 4 cycles on row1 → row1 held stable, no row skipped, done 1 cycle after the row2 handshake.
- Collision: wr_addr=17, wr_data=0xBEEF in the start cycle, base=16 → lane1=0xBEEF with the macro, 18 without. A later read returns 0xBEEF in both builds.
- Reset asserted mid-fetch at row 1 of 4 → next cycle out_valid=0, busy=0, no done. Memory retained, and a new fetch returns the pre-reset data.
- num_rows=0 start → no out_valid, done=1 one cycle later. start during FETCH → ignored, stream unchanged.

Source files
------------

// File: rtl/weight_buffer_pkg.sv
// Shared types, default sizes and address wrap helper for the weight buffer.
// All weight-memory addressing wraps modulo a power-of-two depth.
package weight_buffer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_LANES  = 4;
    localparam int DEF_CNT_W  = 8;

    // depth is a power of two, so masking is the modulo
    function automatic int unsigned wrap_addr(input int unsigned base,
                                              input int unsigned offset,
                                              input int unsigned depth);
        return (base + offset) & (depth - 1);
    endfunction

endpackage

// File: rtl/weight_buffer_ram.sv
// Weight store: one synchronous write port, LANES combinational wrapped read ports.
// Collision lane: wr_data if WEIGHT_BUFFER_BYPASS_EN is defined, else the old word.
module weight_buffer_ram
    import weight_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [LANES*DATA_W-1:0] rd_lanes
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ADDR_W-1:0] lane_addr;
        assign lane_addr = ADDR_W'(wrap_addr(32'(rd_addr), 32'(g), 32'(DEPTH)));
`ifdef WEIGHT_BUFFER_BYPASS_EN
        assign rd_lanes[g*DATA_W +: DATA_W] =
            (wr_en && lane_addr == wr_addr) ? wr_data : mem[lane_addr];
`else
        // the array read sees the pre-edge contents, giving read-before-write
        assign rd_lanes[g*DATA_W +: DATA_W] = mem[lane_addr];
`endif
    end

endmodule

// File: rtl/weight_buffer.sv
// Streams num_rows lane-groups from the weight store; row 0 appears the cycle after start.
// Stalled rows hold stable under !out_ready; optional macro WEIGHT_BUFFER_BYPASS_EN.
module weight_buffer
    import weight_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_rows,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_weights,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    logic [ADDR_W-1:0]       row_addr;
    logic [ADDR_W-1:0]       next_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic [CNT_W-1:0]        rows_left;
    logic [LANES*DATA_W-1:0] rd_lanes;

    assign next_addr = ADDR_W'(wrap_addr(32'(row_addr), 32'(LANES), 32'(DEPTH)));
    assign rd_addr   = (state == IDLE) ? base_addr : next_addr;

    weight_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_lanes (rd_lanes)
    );

    // rows_left counts rows still to be loaded after the one on the output
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_weights <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            row_addr    <= '0;
            rows_left   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            state       <= FETCH;
                            busy        <= 1'b1;
                            out_valid   <= 1'b1;
                            out_weights <= rd_lanes;
                            out_last    <= (num_rows == CNT_W'(1));
                            row_addr    <= base_addr;
                            rows_left   <= num_rows - CNT_W'(1);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_weights <= rd_lanes;
                            row_addr    <= next_addr;
                            rows_left   <= rows_left - CNT_W'(1);
                            out_last    <= (rows_left == CNT_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
